// File: rtl/xbar_arb_pkg.sv
// Shared types for the crossbar packet arbiter.
//   arb_mode_e  : priority-update policy applied at each packet release
//   arb_state_e : grant FSM states
package xbar_arb_pkg;

   typedef enum logic [1:0] {
      ARB_FIXED = 2'd0,
      ARB_RR    = 2'd1,
      ARB_WRR   = 2'd2,
      ARB_RSVD  = 2'd3
   } arb_mode_e;

   typedef enum logic {
      ARB_IDLE   = 1'b0,
      ARB_LOCKED = 1'b1
   } arb_state_e;

endpackage

// File: rtl/priority_order_pick.sv
// Combinational pick: first requester found walking the priority order list.
//   req_valid  : per-requester request bits (indexed by requester ID)
//   order      : requester IDs, order[0] is highest priority
//   pick_valid : at least one requester is active
//   pick_id    : winning requester ID (0 when pick_valid=0)
module priority_order_pick #(
   parameter int unsigned CANDIDATE = 4,
   parameter int unsigned IDX_W     = $clog2(CANDIDATE)
) (
   input  logic [CANDIDATE-1:0] req_valid,
   input  logic [IDX_W-1:0]     order [0:CANDIDATE-1],
   output logic                 pick_valid,
   output logic [IDX_W-1:0]     pick_id
);

   logic [CANDIDATE-1:0] rv;

   // Rearrange requests into priority positions, then take the lowest set position.
   always_comb begin
      rv         = '0;
      pick_valid = 1'b0;
      pick_id    = '0;
      for (int i = 0; i < int'(CANDIDATE); i++) begin
         rv[i] = req_valid[order[i]];
      end
      // Walking downward lets the lowest set position overwrite the rest.
      for (int i = int'(CANDIDATE) - 1; i >= 0; i--) begin
         if (rv[i]) begin
            pick_valid = 1'b1;
            pick_id    = order[i];
         end
      end
   end

endmodule

// File: rtl/xbar_packet_arbiter.sv
// Packet-aware arbiter for one crossbar output port. Grant is held for a whole
// packet; the priority order is updated on release (fixed / RR / WRR).
//   clk, rst      : clock, synchronous active-high reset
//   req_valid     : per-requester beat available
//   req_last      : per-requester current beat ends its packet
//   mode          : arbitration mode (arb_mode_e), sampled at release
//   weight        : WRR packet quota per requester (0 treated as 1)
//   out_ready     : downstream accepts a beat this cycle
//   grant_valid   : grant held
//   grant_number  : granted requester ID (drives the output mux select)
//   grant_onehot  : one-hot grant, zero when idle
//   beat_fire     : a beat of the granted packet moves this cycle
module xbar_packet_arbiter
   import xbar_arb_pkg::*;
#(
   parameter int unsigned CANDIDATE = 4,
   parameter int unsigned WEIGHT_W  = 4,
   parameter int unsigned IDX_W     = $clog2(CANDIDATE)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [CANDIDATE-1:0] req_valid,
   input  logic [CANDIDATE-1:0] req_last,
   input  logic [1:0]           mode,
   input  logic [WEIGHT_W-1:0]  weight [0:CANDIDATE-1],
   input  logic                 out_ready,
   output logic                 grant_valid,
   output logic [IDX_W-1:0]     grant_number,
   output logic [CANDIDATE-1:0] grant_onehot,
   output logic                 beat_fire
);

   arb_state_e          state;
   logic [IDX_W-1:0]    order      [0:CANDIDATE-1];
   logic [IDX_W-1:0]    order_next [0:CANDIDATE-1];
   logic [WEIGHT_W-1:0] credit;
   logic [WEIGHT_W-1:0] credit_next;
   logic [WEIGHT_W-1:0] credit_inc;
   logic [WEIGHT_W-1:0] quota;
   logic [IDX_W-1:0]    g_pos;
   logic                rotate;
   logic                pkt_release;
   logic                pick_valid;
   logic [IDX_W-1:0]    pick_id;

   assign beat_fire   = grant_valid & req_valid[grant_number] & out_ready;
   assign pkt_release = (state == ARB_LOCKED) & beat_fire & req_last[grant_number];

   // Release-time order and credit update; outside a release both hold.
   always_comb begin
      g_pos       = '0;
      rotate      = 1'b0;
      credit_next = credit;
      credit_inc  = (credit == {WEIGHT_W{1'b1}}) ? credit : credit + WEIGHT_W'(1);
      quota       = (weight[grant_number] == '0) ? WEIGHT_W'(1) : weight[grant_number];

      for (int i = 0; i < int'(CANDIDATE); i++) begin
         if (order[i] == grant_number) g_pos = IDX_W'(i);
      end

      if (pkt_release) begin
         case (arb_mode_e'(mode))
            ARB_RR:  rotate = 1'b1;
            ARB_WRR: begin
               if ((credit_inc >= quota) || !req_valid[grant_number]) begin
                  rotate      = 1'b1;
                  credit_next = '0;
               end else begin
                  credit_next = credit_inc;
               end
            end
            default: rotate = 1'b0;
         endcase
      end

      // Rotation: winner leaves position g_pos, later entries move up, winner goes last.
      for (int i = 0; i < int'(CANDIDATE) - 1; i++) begin
         order_next[i] = (rotate && (IDX_W'(i) >= g_pos)) ? order[i+1] : order[i];
      end
      order_next[CANDIDATE-1] = rotate ? grant_number : order[CANDIDATE-1];
   end

   // Single pick, always fed with the post-update order.
   priority_order_pick #(
      .CANDIDATE (CANDIDATE),
      .IDX_W     (IDX_W)
   ) u_pick (
      .req_valid  (req_valid),
      .order      (order_next),
      .pick_valid (pick_valid),
      .pick_id    (pick_id)
   );

   // Grant FSM and priority state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= ARB_IDLE;
         grant_valid  <= 1'b0;
         grant_number <= '0;
         grant_onehot <= '0;
         credit       <= '0;
         for (int i = 0; i < int'(CANDIDATE); i++) begin
            order[i] <= IDX_W'(i);
         end
      end else begin
         credit <= credit_next;
         for (int i = 0; i < int'(CANDIDATE); i++) begin
            order[i] <= order_next[i];
         end
         case (state)
            ARB_IDLE: begin
               if (pick_valid) begin
                  state        <= ARB_LOCKED;
                  grant_valid  <= 1'b1;
                  grant_number <= pick_id;
                  grant_onehot <= CANDIDATE'(1) << pick_id;
               end
            end
            ARB_LOCKED: begin
               // Re-arbitrate in the release cycle so back-to-back packets have no bubble.
               if (pkt_release) begin
                  if (pick_valid) begin
                     grant_number <= pick_id;
                     grant_onehot <= CANDIDATE'(1) << pick_id;
                  end else begin
                     state        <= ARB_IDLE;
                     grant_valid  <= 1'b0;
                     grant_onehot <= '0;
                  end
               end
            end
            default: state <= ARB_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_xbar_packet_arbiter.sv
// Directed, table-driven bench for xbar_packet_arbiter (CANDIDATE=4).
// Each row drives one cycle's inputs and states the outputs expected in that cycle.
module tb_xbar_packet_arbiter;

   localparam int unsigned C = 4;
   localparam int unsigned W = 4;
   localparam logic [1:0] M_FIX = 2'd0;
   localparam logic [1:0] M_RR  = 2'd1;
   localparam logic [1:0] M_WRR = 2'd2;
   localparam logic [1:0] M_RSV = 2'd3;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [C-1:0] req_valid = '0;
   logic [C-1:0] req_last = '0;
   logic [1:0]   mode = M_RR;
   logic [W-1:0] weight [0:C-1];
   logic         out_ready = 1'b0;
   logic         grant_valid;
   logic [1:0]   grant_number;
   logic [C-1:0] grant_onehot;
   logic         beat_fire;

   int tests  = 0;
   int failed = 0;

   typedef struct {
      logic         r;
      logic [1:0]   m;
      logic [C-1:0] rv;
      logic [C-1:0] rl;
      logic         rdy;
      logic         chk;
      logic         gv;
      logic [1:0]   gn;
      logic         bf;
   } vec_t;

   vec_t vecs[$];

   xbar_packet_arbiter #(.CANDIDATE(C), .WEIGHT_W(W)) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_last     (req_last),
      .mode         (mode),
      .weight       (weight),
      .out_ready    (out_ready),
      .grant_valid  (grant_valid),
      .grant_number (grant_number),
      .grant_onehot (grant_onehot),
      .beat_fire    (beat_fire)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(input logic r, input logic [1:0] m, input logic [C-1:0] rv,
                               input logic [C-1:0] rl, input logic rdy, input logic chk,
                               input logic gv, input logic [1:0] gn, input logic bf);
      vec_t v;
      v.r = r; v.m = m; v.rv = rv; v.rl = rl; v.rdy = rdy;
      v.chk = chk; v.gv = gv; v.gn = gn; v.bf = bf;
      return v;
   endfunction

   task automatic step(input logic r, input logic [1:0] m, input logic [C-1:0] rv,
                       input logic [C-1:0] rl, input logic rdy);
      @(negedge clk);
      rst = r; mode = m; req_valid = rv; req_last = rl; out_ready = rdy;
      #1;
   endtask

   task automatic check(input string name, input logic gv, input logic [1:0] gn, input logic bf);
      logic [C-1:0] eoh;
      eoh = gv ? (C'(1) << gn) : '0;
      tests++;
      if (grant_valid !== gv || grant_number !== gn || grant_onehot !== eoh || beat_fire !== bf) begin
         failed++;
         $display("FAIL %s: got gv=%b gn=%0d oh=%b bf=%b, expected gv=%b gn=%0d oh=%b bf=%b",
                  name, grant_valid, grant_number, grant_onehot, beat_fire, gv, gn, eoh, bf);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      weight[0] = 4'd2; weight[1] = 4'd0; weight[2] = 4'd1; weight[3] = 4'd1;

      // First grant, RR order update, paused packet
      vecs.push_back(mk(1, M_RR, 4'b1010, 4'b1010, 0, 1, 0, 0, 0));
      vecs.push_back(mk(0, M_RR, 4'b1010, 4'b1010, 0, 1, 0, 0, 0));
      vecs.push_back(mk(0, M_RR, 4'b1010, 4'b1010, 1, 1, 1, 1, 1));
      vecs.push_back(mk(0, M_RR, 4'b1110, 4'b1110, 1, 1, 1, 3, 1));
      vecs.push_back(mk(0, M_RR, 4'b0110, 4'b0110, 1, 1, 1, 2, 1));
      vecs.push_back(mk(0, M_RR, 4'b0000, 4'b0000, 1, 1, 1, 1, 0));
      vecs.push_back(mk(0, M_RR, 4'b0010, 4'b0010, 1, 1, 1, 1, 1));
      // RR fairness, back-to-back single-beat packets
      vecs.push_back(mk(1, M_RR, 4'b1111, 4'b1111, 1, 0, 0, 0, 0));
      vecs.push_back(mk(0, M_RR, 4'b1111, 4'b1111, 1, 1, 0, 0, 0));
      for (int k = 0; k < 6; k++)
         vecs.push_back(mk(0, M_RR, 4'b1111, 4'b1111, 1, 1, 1, 2'(k % 4), 1));
      // Packet lock across out_ready gaps and foreign req_last
      vecs.push_back(mk(1, M_RR, 4'b0000, 4'b0000, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, M_RR, 4'b0100, 4'b0000, 0, 1, 0, 0, 0));
      vecs.push_back(mk(0, M_RR, 4'b0101, 4'b0000, 1, 1, 1, 2, 1));
      vecs.push_back(mk(0, M_RR, 4'b0101, 4'b0100, 0, 1, 1, 2, 0));
      vecs.push_back(mk(0, M_RR, 4'b0101, 4'b0001, 1, 1, 1, 2, 1));
      vecs.push_back(mk(0, M_RR, 4'b0101, 4'b0100, 1, 1, 1, 2, 1));
      vecs.push_back(mk(0, M_RR, 4'b0001, 4'b0000, 0, 1, 1, 0, 0));
      // Fixed mode and reserved mode
      vecs.push_back(mk(1, M_FIX, 4'b1001, 4'b1001, 1, 0, 0, 0, 0));
      vecs.push_back(mk(0, M_FIX, 4'b1001, 4'b1001, 1, 1, 0, 0, 0));
      for (int k = 0; k < 3; k++)
         vecs.push_back(mk(0, M_FIX, 4'b1001, 4'b1001, 1, 1, 1, 0, 1));
      for (int k = 0; k < 2; k++)
         vecs.push_back(mk(0, M_RSV, 4'b1001, 4'b1001, 1, 1, 1, 0, 1));
      // WRR with weights {2,0,1,1}
      vecs.push_back(mk(1, M_WRR, 4'b1111, 4'b1111, 1, 0, 0, 0, 0));
      vecs.push_back(mk(0, M_WRR, 4'b1111, 4'b1111, 1, 1, 0, 0, 0));
      vecs.push_back(mk(0, M_WRR, 4'b1111, 4'b1111, 1, 1, 1, 0, 1));
      vecs.push_back(mk(0, M_WRR, 4'b1111, 4'b1111, 1, 1, 1, 0, 1));
      vecs.push_back(mk(0, M_WRR, 4'b1111, 4'b1111, 1, 1, 1, 1, 1));
      vecs.push_back(mk(0, M_WRR, 4'b1111, 4'b1111, 1, 1, 1, 2, 1));
      vecs.push_back(mk(0, M_WRR, 4'b1111, 4'b1111, 1, 1, 1, 3, 1));
      vecs.push_back(mk(0, M_WRR, 4'b1111, 4'b1111, 1, 1, 1, 0, 1));
      vecs.push_back(mk(0, M_WRR, 4'b1111, 4'b1111, 1, 1, 1, 0, 1));
      vecs.push_back(mk(0, M_WRR, 4'b1111, 4'b1111, 1, 1, 1, 1, 1));

      step(1, M_RR, '0, '0, 0);
      step(1, M_RR, '0, '0, 0);

      foreach (vecs[i]) begin
         step(vecs[i].r, vecs[i].m, vecs[i].rv, vecs[i].rl, vecs[i].rdy);
         if (vecs[i].chk) check($sformatf("vec%0d", i), vecs[i].gv, vecs[i].gn, vecs[i].bf);
      end

      // Reset in the middle of a 4-beat packet, after the order was rotated
      step(1, M_RR, 4'b0000, 4'b0000, 0);
      step(0, M_RR, 4'b0001, 4'b0000, 0);
      check("mid_idle", 0, 0, 0);
      step(0, M_RR, 4'b0011, 4'b0001, 1);
      check("mid_pre_release", 1, 0, 1);
      step(0, M_RR, 4'b0011, 4'b0000, 1);
      check("mid_beat1", 1, 1, 1);
      step(1, M_RR, 4'b0011, 4'b0000, 1);
      check("mid_beat2_rst", 1, 1, 1);
      step(0, M_RR, 4'b0011, 4'b0000, 1);
      check("mid_after_rst", 0, 0, 0);
      step(0, M_RR, 4'b0011, 4'b0000, 1);
      check("mid_regrant0", 1, 0, 1);

      // Grant latency, bounded wait
      step(1, M_RR, 4'b0000, 4'b0000, 0);
      step(0, M_RR, 4'b1000, 4'b1000, 0);
      lat = 0;
      while (!grant_valid && lat < 8) begin
         step(0, M_RR, 4'b1000, 4'b1000, 0);
         lat++;
      end
      tests++;
      if (lat != 1 || grant_number !== 2'd3) begin
         failed++;
         $display("FAIL latency: got %0d cycles gn=%0d, expected 1 cycle gn=3", lat, grant_number);
      end

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
